// File: rtl/ex_muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit handshake: op issue from the ID/EX register,
// stall request back to the hazard unit, and the completed result toward EX/MEM.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start_E;
  logic [2:0]      op_E;
  logic [XLEN-1:0] srcA_E;
  logic [XLEN-1:0] srcB_E;
  logic [4:0]      rd_E;
  logic            flush_E;
  logic            advance_E;
  logic            stall_req;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd;

  modport master (
    output start_E, op_E, srcA_E, srcB_E, rd_E, flush_E, advance_E,
    input  stall_req, busy, result_valid, result, result_rd
  );

  modport slave (
    input  start_E, op_E, srcA_E, srcB_E, rd_E, flush_E, advance_E,
    output stall_req, busy, result_valid, result, result_rd
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: single-cycle-registered multiply, bit-serial restoring divide.
// Holds the pipeline via stall_req while working and presents the result until EX advances.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  counter_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, quo_q, dvs_q;
  logic [XLEN:0]     rem_q;
  logic [4:0]        rd_q;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   res_q;
  logic [4:0]        res_rd_q;

  // accept-cycle decode
  logic            accept, div_zero, div_ovf, special, a_neg, b_neg;
  logic [XLEN-1:0] special_res, a_mag, b_mag;

  assign accept      = (state_q == IDLE) & bus.start_E & ~bus.flush_E;
  assign div_zero    = (bus.srcB_E == '0);
  assign div_ovf     = ~bus.op_E[0] & (bus.srcA_E == SMIN) & (bus.srcB_E == '1);
  assign special     = bus.op_E[2] & (div_zero | div_ovf);
  assign special_res = bus.op_E[1] ? (div_zero ? bus.srcA_E : '0)
                                   : (div_zero ? '1 : SMIN);
  assign a_neg       = ~bus.op_E[0] & bus.srcA_E[XLEN-1];
  assign b_neg       = ~bus.op_E[0] & bus.srcB_E[XLEN-1];
  assign a_mag       = a_neg ? -bus.srcA_E : bus.srcA_E;
  assign b_mag       = b_neg ? -bus.srcB_E : bus.srcB_E;

  // Multiply: 33-bit extended operands; the low 2*XLEN bits of the product are exact.
  logic              a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_w, b_w, prod;
  logic [XLEN-1:0]   mul_res;

  assign a_sgn   = ~(op_q[1] & op_q[0]) & a_q[XLEN-1];
  assign b_sgn   = ~op_q[1] & b_q[XLEN-1];
  assign a_w     = {{XLEN{a_sgn}}, a_q};
  assign b_w     = {{XLEN{b_sgn}}, b_q};
  assign prod    = a_w * b_w;
  assign mul_res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Restoring divide step; rem carries one spare bit so the borrow lands in shifted's top bit.
  logic [XLEN+1:0] shifted, diff;
  logic            q_bit;
  logic [XLEN:0]   rem_nx;
  logic [XLEN-1:0] quo_nx, r_fin, div_res;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {2'b00, dvs_q};
  assign q_bit   = ~diff[XLEN+1];
  assign rem_nx  = q_bit ? diff[XLEN:0] : shifted[XLEN:0];
  assign quo_nx  = {quo_q[XLEN-2:0], q_bit};
  assign r_fin   = rem_nx[XLEN-1:0];
  assign div_res = op_q[1] ? (neg_r ? -r_fin : r_fin)
                           : (neg_q ? -quo_nx : quo_nx);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = !bus.op_E[2] ? MUL : (special ? DONE : DIV);
      MUL:  state_d = DONE;
      DIV:  if (counter_q == CNT_W'(1)) state_d = DONE;
      DONE: if (bus.advance_E) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush_E) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      counter_q <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      res_q     <= '0;
      res_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= bus.op_E;
        a_q   <= bus.srcA_E;
        b_q   <= bus.srcB_E;
        rd_q  <= bus.rd_E;
        quo_q <= a_mag;
        dvs_q <= b_mag;
        rem_q <= '0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        if (state_d == DIV) counter_q <= CNT_W'(XLEN);
      end
      if (state_q == DIV) begin
        rem_q     <= rem_nx;
        quo_q     <= quo_nx;
        counter_q <= counter_q - CNT_W'(1);
      end
      if (state_q != DONE && state_d == DONE) begin
        unique case (state_q)
          IDLE:    begin res_q <= special_res; res_rd_q <= bus.rd_E; end
          MUL:     begin res_q <= mul_res;     res_rd_q <= rd_q;     end
          default: begin res_q <= div_res;     res_rd_q <= rd_q;     end
        endcase
      end
    end
  end

  assign bus.stall_req    = accept | (state_q == MUL) | (state_q == DIV);
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.result       = res_q;
  assign bus.result_rd    = res_rd_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized scoreboard bench for ex_muldiv_unit: driver pushes model results,
// a negedge monitor pops and compares whenever result_valid is presented.
module tb_ex_muldiv_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.XLEN(XLEN)) bus();
  ex_muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: RV32M semantics via 64-bit arithmetic and native signed division.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, ub;
    logic [63:0] p, ua64, ub64;
    int ia, ib;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ub = longint'(b);
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0: begin p = sa * sb_; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == SMIN && b == 32'hFFFF_FFFF) return SMIN;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == SMIN && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Monitor: compare every presented cycle, retire when EX advances (or flushes).
  always @(negedge clk) begin
    if (rst_n && bus.result_valid) begin
      if (sb.size() == 0) chk("spurious_valid", bus.result_valid, 1'b0);
      else begin
        chk("result", bus.result, sb[0].res);
        chk("result_rd", bus.result_rd, sb[0].rd);
        if (bus.advance_E || bus.flush_E) void'(sb.pop_front());
      end
    end
  end

  // Called just after a posedge with the unit idle; returns just after a posedge, idle.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold);
    exp_t e;
    int lat, cyc;
    bit stall_ok, held_ok;
    e.res = model(op, a, b);
    e.rd = rd;
    sb.push_back(e);
    lat = latency(op, a, b);
    bus.start_E = 1'b1;
    bus.op_E = op;
    bus.srcA_E = a;
    bus.srcB_E = b;
    bus.rd_E = rd;
    bus.advance_E = (hold == 0);
    cyc = 0;
    stall_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.result_valid) break;
      if (!bus.stall_req || (cyc > 0 && !bus.busy)) stall_ok = 1'b0;
      cyc++;
      if (cyc >= 100) begin
        $display("FAIL timeout: no result_valid for op %0d within 100 cycles", op);
        $fatal(1, "timeout");
      end
    end
    chk("latency", cyc, lat);
    chk("stall_while_busy", stall_ok, 1'b1);
    chk("stall_in_done", bus.stall_req, 1'b0);
    held_ok = 1'b1;
    for (int h = 1; h <= hold; h++) begin
      @(posedge clk); #1;
      if (h == hold) bus.advance_E = 1'b1;
      @(negedge clk);
      if (!bus.result_valid || bus.stall_req) held_ok = 1'b0;
    end
    if (hold > 0) chk("held_in_done", held_ok, 1'b1);
    @(posedge clk); #1;
    bus.start_E = 1'b0;
    bus.advance_E = 1'b0;
  endtask

  // Issue an op and flush it in cycle fcyc (counted from the accept cycle).
  task automatic do_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int fcyc);
    bus.start_E = 1'b1;
    bus.op_E = op;
    bus.srcA_E = a;
    bus.srcB_E = b;
    bus.rd_E = rd;
    bus.advance_E = 1'b0;
    for (int i = 0; i < fcyc; i++) begin
      @(posedge clk); #1;
    end
    bus.flush_E = 1'b1;
    @(posedge clk); #1;
    bus.flush_E = 1'b0;
    bus.start_E = 1'b0;
    @(negedge clk);
    chk("flush_busy", bus.busy, 1'b0);
    chk("flush_valid", bus.result_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    int sel;
    bus.start_E = 1'b0;
    bus.op_E = '0;
    bus.srcA_E = '0;
    bus.srcB_E = '0;
    bus.rd_E = '0;
    bus.flush_E = 1'b0;
    bus.advance_E = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_valid", bus.result_valid, 1'b0);
    chk("rst_stall", bus.stall_req, 1'b0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_rd", bus.result_rd, 5'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed cases
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 0);
    do_op(3'd5, 32'd5, 32'd0, 5'd11, 0);
    do_op(3'd7, 32'd5, 32'd0, 5'd12, 0);
    do_op(3'd4, SMIN, 32'hFFFF_FFFF, 5'd13, 0);
    do_op(3'd6, SMIN, 32'hFFFF_FFFF, 5'd14, 0);
    do_op(3'd5, 32'hFFFF_FFFF, 32'd3, 5'd15, 3);
    do_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd16, 2);

    // flush mid-divide, then an immediate new op
    do_flush(3'd4, 32'd1000, 32'd7, 5'd20, 10);
    do_op(3'd6, 32'd1000, 32'hFFFF_FFF9, 5'd21, 0);
    do_flush(3'd5, 32'hDEAD_BEEF, 32'd13, 5'd22, 32);
    do_flush(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 5'd23, 1);

    // flush beats start in IDLE
    bus.start_E = 1'b1;
    bus.flush_E = 1'b1;
    bus.op_E = 3'd0;
    @(negedge clk);
    chk("flush_start_stall", bus.stall_req, 1'b0);
    @(posedge clk); #1;
    bus.start_E = 1'b0;
    bus.flush_E = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", bus.busy, 1'b0);
    @(posedge clk); #1;

    // randomized traffic with corner-biased operands
    for (int i = 0; i < 36; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = SMIN; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 40); b = $urandom_range(1, 9); end
      else if (sel == 3) b = 32'($signed(-$urandom_range(1, 9)));
      do_op(op, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end

    // reset during a divide clears everything and reports nothing
    bus.start_E = 1'b1;
    bus.op_E = 3'd4;
    bus.srcA_E = 32'd12345;
    bus.srcB_E = 32'd17;
    bus.rd_E = 5'd30;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    bus.start_E = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_valid", bus.result_valid, 1'b0);
    chk("midrst_stall", bus.stall_req, 1'b0);
    chk("midrst_result", bus.result, 32'h0);
    chk("midrst_rd", bus.result_rd, 5'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    do_op(3'd7, 32'd100, 32'd7, 5'd31, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
